// File: rtl/traffic_timer.sv
// Seconds countdown timer: a prescaler divides clk into one-second ticks and a
// loadable down-counter reports remaining seconds, expiry and a done pulse.
module traffic_timer #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             timer_load,
  input  logic [CNT_W-1:0] timer_init,
  output logic [CNT_W-1:0] timer_out,
  output logic             expired,
  output logic             done,
  output logic             tick
);

  // A one-cycle second still needs a one-bit prescaler that never leaves 0.
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count;
  logic [PW-1:0]    prescaler;
  logic             rollover;
  logic             last_sec;

  assign rollover  = (prescaler == PRE_LAST);
  assign last_sec  = (count == CNT_W'(1));
  assign timer_out = count;
  assign expired   = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else if (timer_load) begin
      // A load restarts the second from zero and swallows any pending rollover.
      count     <= timer_init;
      prescaler <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else if (timer_en) begin
      tick <= rollover;
      done <= rollover && last_sec;
      if (rollover) begin
        prescaler <= '0;
        if (!expired) count <= count - CNT_W'(1);
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Randomized and directed bench for traffic_timer, checked against a model
// that derives remaining seconds from enabled edges elapsed since the last load.
module tb_traffic_timer;

  localparam int T = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          timer_en;
  logic          timer_load;
  logic [CW-1:0] timer_init;
  logic [CW-1:0] timer_out;
  logic          expired;
  logic          done;
  logic          tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: value of the last load and enabled edges counted since it.
  int load_val = 0;
  int total    = 0;
  logic exp_tick = 1'b0;
  logic exp_done = 1'b0;

  traffic_timer #(.TICKS_PER_SEC(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .timer_en(timer_en), .timer_load(timer_load),
    .timer_init(timer_init), .timer_out(timer_out), .expired(expired),
    .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int exp_out();
    if (total / T >= load_val) return 0;
    return load_val - total / T;
  endfunction

  function automatic logic [CW+2:0] exp_vec();
    return {CW'(exp_out()), (exp_out() == 0), exp_tick, exp_done};
  endfunction

  task automatic model_reset();
    load_val = 0;
    total    = 0;
    exp_tick = 1'b0;
    exp_done = 1'b0;
  endtask

  // Drive inputs at a falling edge, apply one rising edge, return at the next falling edge.
  task automatic step(input logic ld, input logic en, input int init);
    timer_load = ld;
    timer_en   = en;
    timer_init = CW'(init);
    @(posedge clk);
    exp_tick = 1'b0;
    exp_done = 1'b0;
    if (ld) begin
      load_val = init;
      total    = 0;
    end else if (en) begin
      total++;
      if (total % T == 0) exp_tick = 1'b1;
      if (load_val > 0 && total == load_val * T) exp_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; timer_en = 1'b0; timer_load = 1'b0; timer_init = '0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({timer_out, expired, tick, done} !== {CW'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_initial: got %b want %b", {timer_out, expired, tick, done}, {CW'(0), 3'b100});
    else n_pass++;
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 7);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0);
    // tick is high now; reset lands between edges and must clear everything at once.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({timer_out, expired, tick, done} !== {CW'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_async: got %b want %b", {timer_out, expired, tick, done}, {CW'(0), 3'b100});
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_countdown();
    int ticks = 0;
    int dones = 0;
    n_checks++;
    if (expired !== 1'b1) $display("FAIL cd_pre_expired: got %b want 1", expired);
    else n_pass++;
    step(1'b1, 1'b0, 5);
    n_checks++;
    if ({timer_out, expired} !== {CW'(5), 1'b0})
      $display("FAIL cd_load: got %0d/%b want 5/0", timer_out, expired);
    else n_pass++;
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 1'b1, 0);
      ticks += tick;
      dones += done;
      n_checks++;
      if ({timer_out, expired, tick, done} !== exp_vec())
        $display("FAIL cd_cycle%0d: got %b want %b", i, {timer_out, expired, tick, done}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (dones !== 1 || ticks !== 6 || timer_out !== CW'(0))
      $display("FAIL cd_totals: got done=%0d tick=%0d out=%0d want 1 6 0", dones, ticks, timer_out);
    else n_pass++;
  endtask

  task automatic test_load_priority();
    step(1'b1, 1'b0, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 10);
    n_checks++;
    if ({timer_out, tick, done} !== {CW'(10), 1'b0, 1'b0})
      $display("FAIL prio_load: got %0d tick=%b done=%b want 10 0 0", timer_out, tick, done);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 0);
      n_checks++;
      if ({timer_out, expired, tick, done} !== exp_vec())
        $display("FAIL prio_cycle%0d: got %b want %b", i, {timer_out, expired, tick, done}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (timer_out !== CW'(9)) $display("FAIL prio_first_dec: got %0d want 9", timer_out);
    else n_pass++;
  endtask

  task automatic test_pause();
    step(1'b1, 1'b0, 2);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0, 0);
      n_checks++;
      if ({timer_out, tick, done} !== {CW'(2), 1'b0, 1'b0})
        $display("FAIL pause_hold%0d: got %0d tick=%b done=%b want 2 0 0", i, timer_out, tick, done);
      else n_pass++;
    end
    step(1'b0, 1'b1, 0);
    n_checks++;
    if (timer_out !== CW'(2)) $display("FAIL pause_resume1: got %0d want 2", timer_out);
    else n_pass++;
    step(1'b0, 1'b1, 0);
    n_checks++;
    if ({timer_out, tick} !== {CW'(1), 1'b1})
      $display("FAIL pause_resume2: got %0d tick=%b want 1 1", timer_out, tick);
    else n_pass++;
  endtask

  task automatic test_zero_load();
    int ticks = 0;
    step(1'b1, 1'b1, 0);
    n_checks++;
    if ({timer_out, expired, done} !== {CW'(0), 1'b1, 1'b0})
      $display("FAIL zero_load: got %0d exp=%b done=%b want 0 1 0", timer_out, expired, done);
    else n_pass++;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 0);
      ticks += tick;
      n_checks++;
      if ({timer_out, expired, tick, done} !== {CW'(0), 1'b1, (i % 4 == 0), 1'b0})
        $display("FAIL zero_cycle%0d: got %b want %b", i, {timer_out, expired, tick, done},
                 {CW'(0), 1'b1, (i % 4 == 0), 1'b0});
      else n_pass++;
    end
    n_checks++;
    if (ticks !== 3) $display("FAIL zero_ticks: got %0d want 3", ticks);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, 9);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0);
    n_checks++;
    if (timer_out !== CW'(exp_out())) $display("FAIL mid_before: got %0d want %0d", timer_out, exp_out());
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({timer_out, expired} !== {CW'(0), 1'b1})
      $display("FAIL mid_async: got %0d exp=%b want 0 1", timer_out, expired);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 0);
      n_checks++;
      if ({timer_out, expired, done} !== {CW'(0), 1'b1, 1'b0})
        $display("FAIL mid_idle%0d: got %0d exp=%b done=%b want 0 1 0", i, timer_out, expired, done);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic ld, en;
    int init;
    for (int i = 0; i < 400; i++) begin
      ld   = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 3) != 0);
      init = $urandom_range(0, 15);
      step(ld, en, init);
      n_checks++;
      if ({timer_out, expired, tick, done} !== exp_vec())
        $display("FAIL rand_cycle%0d: got %b want %b", i, {timer_out, expired, tick, done}, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_load_priority();
    test_pause();
    test_zero_load();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000, SHALL set the clk cycles per one-second tick; legal range 1 to 2^32-1.
REQ-002 Parameter CNT_W, default 4, SHALL set the width of the count, timer_init and timer_out.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 timer_en  input  1  level; enables prescaler advance and countdown.
REQ-006 timer_load  input  1  level; loads timer_init into the count.
REQ-007 timer_init  input  CNT_W  load value in seconds.
REQ-008 timer_out  output  CNT_W  current remaining seconds, driven directly from the count register.
REQ-009 expired  output  1  combinational; high whenever timer_out == 0.
REQ-010 done  output  1  registered one-cycle pulse on the countdown-driven transition to 0.
REQ-011 tick  output  1  registered one-cycle pulse at each one-second prescaler rollover.

Function
REQ-012 The prescaler register SHALL be wide enough to hold TICKS_PER_SEC-1.
REQ-013 Per-edge priority SHALL be: rst, then timer_load, then timer_en, then hold.
REQ-014 When timer_load=1 at a clk edge, the block SHALL set count to timer_init and prescaler to 0.
REQ-015 A load SHALL force tick=0 and done=0 in the following cycle, whatever the value of timer_en.
REQ-016 The load value SHALL appear on timer_out one cycle after the load edge.
REQ-017 When timer_load=0 and timer_en=1, the prescaler SHALL increment by 1 per edge.
REQ-018 On the edge where prescaler == TICKS_PER_SEC-1, the prescaler SHALL wrap to 0 and tick SHALL pulse for the next cycle.
REQ-019 On a rollover edge with count != 0, count SHALL decrement by 1.
REQ-020 On a rollover edge with count == 1, done SHALL pulse in the same cycle that timer_out first reads 0.
REQ-021 On a rollover edge with count == 0, count SHALL stay at 0 with no wrap and no done pulse; tick SHALL still pulse.
REQ-022 When timer_load=0 and timer_en=0, count and prescaler SHALL hold, and tick and done SHALL be 0.
REQ-023 A pause SHALL preserve the elapsed part of the current second.
REQ-024 With TICKS_PER_SEC=1, every enabled, non-load edge SHALL be a rollover.
REQ-025 Loading 0 SHALL give timer_out=0 and expired=1 in the next cycle, with no done pulse.
REQ-026 Loading a nonzero value while expired SHALL drop expired in the next cycle.
REQ-027 Asserting timer_load on the same edge as a pending rollover SHALL discard the rollover: no decrement, no tick, no done.
REQ-028 Latency from the first enabled edge after a load of N (N>0) to timer_out==0 SHALL be exactly N*TICKS_PER_SEC enabled edges, counting only edges with timer_en=1 and timer_load=0.
REQ-029 The block SHALL be compatible with a Moore controller that loads on one cycle, enables on the following cycles and polls timer_out==0.

Reset
REQ-030 On rst assertion, without waiting for a clk edge, count, prescaler, tick and done SHALL be 0, giving timer_out=0 and expired=1.
REQ-031 Reset SHALL override any load or countdown in progress.
REQ-032 After rst deasserts, the block SHALL remain idle at 0 until the first load.

Verification (TICKS_PER_SEC=4, CNT_W=4)
REQ-033 Reset: assert rst between clk edges -> timer_out=0, expired=1, done=0, tick=0 immediately, before the next edge.
REQ-034 Countdown: load 5, then timer_en=1 for 24 cycles -> timer_out reads 5,4,3,2,1,0, decrementing after every 4th enabled edge; done pulses exactly once, together with the first 0; tick pulses 6 times; timer_out stays 0.
REQ-035 Load priority: while count=3 with prescaler=3, apply timer_load=1, timer_en=1, timer_init=10 -> next cycle timer_out=10, prescaler=0, tick=0, done=0, no decrement.
REQ-036 Pause: load 2, enable 2 cycles, drop timer_en for 7 cycles, then re-enable -> timer_out holds 2 during the pause; first decrement after 2 further enabled edges.
REQ-037 Zero load: load 0 with timer_en=1 -> timer_out=0, expired=1, done never asserts, tick keeps pulsing every 4 cycles.
REQ-038 Mid-count reset: load 9, enable 10 cycles, assert rst asynchronously -> timer_out=0 at once; after release, timer_out stays 0 until the next load.
